mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port memory arbiter between several requesters using the RV32I multicycle memory handshake (`read`/`write` held until `resp`) and one downstream memory port with the same handshake. It is the successor to the single-requester top-level memory interface. Instruction fetch, data access and future requesters share one physical memory under round-robin fairness. A watchdog terminates transactions the memory never acknowledges and latches a sticky error.

## Interface
Parameters:
- `N_PORTS`, default 2: number of requesters; legal range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; a multiple of 8.
- `TIMEOUT`, default 255: maximum wait cycles for `mem_resp` per transaction; legal range 1..65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `port_read`  in  N_PORTS  per-port read request.
- `port_write`  in  N_PORTS  per-port write request.
- `port_address`  in  N_PORTS*ADDR_W  port i occupies bits [i*ADDR_W +: ADDR_W].
- `port_wdata`  in  N_PORTS*DATA_W  packed per port.
- `port_byte_enable`  in  N_PORTS*DATA_W/8  packed per port.
- `port_resp`  out  N_PORTS  one-hot completion strobe.
- `port_rdata`  out  DATA_W  read data, shared by all ports; valid only with a `port_resp` bit.
- `mem_read`, `mem_write`  out  1  downstream request.
- `mem_address`  out  ADDR_W  downstream address.
- `mem_wdata`  out  DATA_W  downstream write data.
- `mem_byte_enable`  out  DATA_W/8  downstream byte enables.
- `mem_resp`  in  1  downstream completion.
- `mem_rdata`  in  DATA_W  downstream read data.
- `err`  out  1  sticky timeout flag.
- `err_port`  out  $clog2(N_PORTS)  port index of the first timeout.

## Operation
- FSM states are IDLE and BUSY. Reset enters IDLE.
- **IDLE:**
  - Port i is requesting when `port_read[i] | port_write[i]`.
  - Arbitration is round-robin. The search starts at `rr_ptr` and wraps modulo N_PORTS. The first requesting port wins.
  - On a winner, the following are registered at the clock edge:
    - grant index `gnt`;
    - op: write if `port_write[gnt]`, else read (write wins if both are set);
    - the winner's address, wdata and byte_enable.
  - At the same edge: `rr_ptr <= gnt+1` (mod N_PORTS), the wait counter clears to 0, and the FSM goes to BUSY.
  - No requesters means the FSM stays in IDLE.
- **BUSY:**
  - `mem_read`/`mem_write` follow the registered op. `mem_address`, `mem_wdata` and `mem_byte_enable` are driven from the registers and are stable for the whole transaction.
  - The wait counter increments each cycle while `mem_resp` is 0.
  - `mem_resp=1`:
    - `port_resp[gnt]=1` in the same cycle (combinational);
    - `port_rdata=mem_rdata`;
    - the FSM returns to IDLE at the next edge.
  - Counter reaches TIMEOUT with `mem_resp=0`:
    - `port_resp[gnt]=1` and `port_rdata=0` that cycle;
    - the FSM goes to IDLE;
    - if `err` is 0, set `err=1` and `err_port=gnt`.
  - If `mem_resp` and the timeout coincide, the transaction completes normally and there is no error.
- Outside BUSY: `port_resp=0`, `mem_read=mem_write=0`, `port_rdata=0`.
- Request changes at ports are ignored during BUSY, because the transaction is latched.
- `err` and `err_port` clear only on reset.
- Reset mid-transaction: all outputs return to reset values immediately and the transaction is dropped. Requesters restart after reset.

## Timing
- Reset values:
  - FSM=IDLE, `rr_ptr`=0, `gnt`=0, counter=0;
  - all latched registers 0;
  - `port_resp`=0, `port_rdata`=0, `mem_read`=`mem_write`=0, `mem_address`=0, `mem_wdata`=0, `mem_byte_enable`=0;
  - `err`=0, `err_port`=0.
- Latency: a request seen in IDLE at edge k appears on `mem_*` from cycle k+1.
- `port_resp` is asserted in the same cycle as `mem_resp`. Minimum transaction is 2 cycles (IDLE, then BUSY with immediate resp).
- There is always one IDLE cycle between transactions. A served port must deassert its request in the cycle after its `port_resp`; this is the standard handshake, and in that IDLE cycle it does not re-arbitrate.
- Timeout fires in the cycle where the counter equals TIMEOUT, i.e. the (TIMEOUT+1)-th BUSY cycle.

## Test plan
- Single port: N_PORTS=2; port0 reads 0x0000_0100; memory answers after 3 cycles with 0xDEADBEEF. Required: `mem_read` high 4 cycles with address 0x100; `port_resp`=2'b01 with `port_rdata`=0xDEADBEEF; `port_resp[1]` stays 0.
- Round-robin: N_PORTS=4; all ports hold requests continuously, re-requesting after each resp. Required: grant order 0,1,2,3,0,1, with one IDLE cycle between grants.
- Write vs read, byte enables: port1 asserts both read and write with be=4'b0011 and wdata 0x1234_5678. Required: `mem_write`=1, `mem_read`=0, `mem_byte_enable`=4'b0011, `mem_wdata`=0x12345678.
- Latch stability: port0 changes its address from 0x40 to 0x80 mid-BUSY. Required: `mem_address` stays 0x40 until resp.
- Timeout: TIMEOUT=4; port1 reads and `mem_resp` is never asserted. Required: `port_resp[1]`=1 with `port_rdata`=0 in BUSY cycle 5; `err`=1 and `err_port`=1. A later timeout on port0 leaves `err_port`=1.
- Async reset: assert `rst_n`=0 mid-BUSY, between clock edges. Required: `mem_read`, `port_resp` and `err` drop to 0 immediately; after release, the FSM is in IDLE and `rr_ptr`=0, so port0 wins the next contention against port1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin N-port arbiter onto one memory port using the read/write-until-resp handshake.
// A per-transaction watchdog completes stalled accesses and latches a sticky error.
module mem_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             port_read,
  input  logic [N_PORTS-1:0]             port_write,
  input  logic [N_PORTS*ADDR_W-1:0]      port_address,
  input  logic [N_PORTS*DATA_W-1:0]      port_wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0]  port_byte_enable,
  output logic [N_PORTS-1:0]             port_resp,
  output logic [DATA_W-1:0]              port_rdata,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic [DATA_W/8-1:0]            mem_byte_enable,
  input  logic                           mem_resp,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           err,
  output logic [$clog2(N_PORTS)-1:0]     err_port
);

  localparam int unsigned IDX_W = $clog2(N_PORTS);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_be;
  logic               r_err;
  logic [IDX_W-1:0]   r_err_port;

  logic [N_PORTS-1:0] w_req;
  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_next_ptr;
  int unsigned        w_scan;
  logic               w_busy;
  logic               w_at_limit;
  logic               w_done;
  logic               w_timeout;

  assign w_req = port_read | port_write;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      w_scan = (32'(r_rr_ptr) + k) % N_PORTS;
      if (!w_found && w_req[IDX_W'(w_scan)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_scan);
      end
    end
  end

  assign w_next_ptr = (w_winner == IDX_W'(N_PORTS - 1)) ? '0 : w_winner + 1'b1;

  assign w_busy     = (r_state == S_BUSY);
  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT));
  assign w_done     = w_busy && (mem_resp || w_at_limit);
  assign w_timeout  = w_busy && !mem_resp && w_at_limit;

  // Completion is reported in the same cycle the memory answers (or the watchdog fires).
  assign port_resp       = w_done ? (N_PORTS'(1) << r_gnt) : '0;
  assign port_rdata      = (w_busy && mem_resp) ? mem_rdata : '0;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;
  assign mem_byte_enable = r_be;
  assign err             = r_err;
  assign err_port        = r_err_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_err       <= 1'b0;
      r_err_port  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_BUSY;
            r_gnt       <= w_winner;
            r_rr_ptr    <= w_next_ptr;
            r_cnt       <= '0;
            r_mem_write <= port_write[w_winner];
            r_mem_read  <= !port_write[w_winner];
            r_addr      <= port_address[w_winner*ADDR_W +: ADDR_W];
            r_wdata     <= port_wdata[w_winner*DATA_W +: DATA_W];
            r_be        <= port_byte_enable[w_winner*BE_W +: BE_W];
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state     <= S_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            // Only the first timeout is recorded; later ones leave the port index alone.
            if (w_timeout && !r_err) begin
              r_err      <= 1'b1;
              r_err_port <= r_gnt;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    port_read;
  logic [N-1:0]    port_write;
  logic [N*AW-1:0] port_address;
  logic [N*DW-1:0] port_wdata;
  logic [N*BW-1:0] port_byte_enable;
  logic [N-1:0]    port_resp;
  logic [DW-1:0]   port_rdata;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_byte_enable;
  logic            mem_resp;
  logic [DW-1:0]   mem_rdata;
  logic            err;
  logic [1:0]      err_port;

  always #5 clk = ~clk;

  mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_byte_enable(port_byte_enable),
    .port_resp(port_resp), .port_rdata(port_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .err(err), .err_port(err_port)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, served in round-robin order.
  bit          m_busy     = 1'b0;
  int          m_gnt      = 0;
  int          m_ptr      = 0;
  int          m_cycle    = 0;
  bit          m_wr       = 1'b0;
  logic [31:0] m_addr     = '0;
  logic [31:0] m_wdata    = '0;
  logic [3:0]  m_be       = '0;
  bit          m_err      = 1'b0;
  int          m_err_port = 0;
  int          m_win;

  function automatic int pick(input int ptr, input logic [N-1:0] rd, input logic [N-1:0] wr);
    for (int k = 0; k < N; k++) begin
      if (rd[(ptr + k) % N] || wr[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  assign m_win = pick(m_ptr, port_read, port_write);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_gnt <= 0; m_ptr <= 0; m_cycle <= 0; m_wr <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_be <= '0; m_err <= 1'b0; m_err_port <= 0;
    end else if (!m_busy) begin
      if (m_win >= 0) begin
        m_busy  <= 1'b1;
        m_gnt   <= m_win;
        m_ptr   <= (m_win + 1) % N;
        m_cycle <= 1;
        m_wr    <= port_write[m_win];
        m_addr  <= port_address[m_win*AW +: AW];
        m_wdata <= port_wdata[m_win*DW +: DW];
        m_be    <= port_byte_enable[m_win*BW +: BW];
      end
    end else if (mem_resp || m_cycle == TO + 1) begin
      m_busy <= 1'b0;
      if (!mem_resp && !m_err) begin
        m_err      <= 1'b1;
        m_err_port <= m_gnt;
      end
    end else begin
      m_cycle <= m_cycle + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_mem_read",  mem_read,  m_busy && !m_wr);
      chk("m_mem_write", mem_write, m_busy && m_wr);
      chk("m_mem_addr",  mem_address, m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
      chk("m_mem_be",    mem_byte_enable, m_be);
      chk("m_port_resp", port_resp,
          (m_busy && (mem_resp || m_cycle == TO + 1)) ? (64'd1 << m_gnt) : 64'd0);
      chk("m_port_rdata", port_rdata, (m_busy && mem_resp) ? mem_rdata : 32'd0);
      chk("m_err",      err, m_err);
      chk("m_err_port", err_port, m_err_port);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    port_read[p]                = rd;
    port_write[p]               = wr;
    port_address[p*AW +: AW]    = a;
    port_wdata[p*DW +: DW]      = d;
    port_byte_enable[p*BW +: BW] = be;
  endtask

  task automatic clear_ports();
    port_read = '0; port_write = '0; port_address = '0; port_wdata = '0; port_byte_enable = '0;
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};
  int last;
  int rd_cycles;

  initial begin
    clear_ports();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_resp", port_resp, 4'b0000);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_err", err, 1'b0);
    tick();
    rst_n = 1'b1;

    // Round-robin with all ports requesting; served port drops for its IDLE cycle.
    for (int i = 0; i < N; i++) set_port(i, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF);
    mem_resp  = 1'b1;
    mem_rdata = 32'hA5A5_0000;
    last = -1;
    for (int g = 0; g < 6; g++) begin
      tick();
      if (last >= 0) port_read[last] = 1'b1;
      @(negedge clk);
      chk("rr_gnt", port_resp, 64'd1 << exp_order[g]);
      chk("rr_addr", mem_address, 32'h1000 + 32'(exp_order[g] * 4));
      last = exp_order[g];
      tick();
      port_read[last] = 1'b0;
      @(negedge clk);
      chk("rr_idle", {mem_read, port_resp}, 5'b0);
    end
    clear_ports();
    mem_resp = 1'b0;

    // Single read, memory answers in the 4th BUSY cycle.
    tick();
    set_port(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    rd_cycles = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) begin mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      rd_cycles += int'(mem_read);
      chk("sp_addr", mem_address, 32'h100);
      chk("sp_resp1", port_resp[1], 1'b0);
      if (i == 4) begin
        chk("sp_resp", port_resp, 4'b0001);
        chk("sp_rdata", port_rdata, 32'hDEAD_BEEF);
      end else begin
        chk("sp_resp_wait", port_resp, 4'b0000);
      end
    end
    tick();
    clear_ports();
    mem_resp = 1'b0;
    @(negedge clk);
    rd_cycles += int'(mem_read);
    chk("sp_rd_cycles", rd_cycles, 4);

    // Read and write both set: write wins.
    tick();
    set_port(1, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("wr_write", mem_write, 1'b1);
    chk("wr_read", mem_read, 1'b0);
    chk("wr_be", mem_byte_enable, 4'b0011);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_resp", port_resp, 4'b0010);
    tick();
    clear_ports();
    mem_resp = 1'b0;

    // Address changes mid-transaction must not leak through.
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 1) port_address[0 +: AW] = 32'h80;
      if (i == 3) mem_resp = 1'b1;
      @(negedge clk);
      chk("latch_addr", mem_address, 32'h40);
    end
    chk("latch_resp", port_resp, 4'b0001);
    tick();
    clear_ports();
    mem_resp = 1'b0;

    // Response arriving exactly at the timeout cycle completes normally.
    set_port(2, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) mem_resp = 1'b1;
      @(negedge clk);
      if (i < 5) chk("co_wait", port_resp, 4'b0000);
    end
    chk("co_resp", port_resp, 4'b0100);
    chk("co_rdata", port_rdata, 32'hCAFE_F00D);
    tick();
    clear_ports();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("co_no_err", err, 1'b0);

    // Timeout on port1: forced completion in BUSY cycle 5 with zero data.
    set_port(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      if (i < 5) chk("to_wait", port_resp, 4'b0000);
    end
    chk("to_resp", port_resp, 4'b0010);
    chk("to_rdata", port_rdata, 32'h0);
    tick();
    clear_ports();
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_err_port", err_port, 2'd1);
    chk("to_idle", mem_read, 1'b0);

    // Second timeout on port0 keeps the first error's port.
    set_port(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
    end
    chk("to2_resp", port_resp, 4'b0001);
    tick();
    clear_ports();
    @(negedge clk);
    chk("to2_err", err, 1'b1);
    chk("to2_err_port", err_port, 2'd1);

    // Asynchronous reset in the middle of a transaction.
    set_port(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("ar_pre_resp", port_resp, 4'b0001);
    chk("ar_pre_err", err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_read", mem_read, 1'b0);
    chk("ar_port_resp", port_resp, 4'b0000);
    chk("ar_err", err, 1'b0);
    chk("ar_err_port", err_port, 2'd0);
    chk("ar_addr", mem_address, 32'h0);
    mem_resp = 1'b0;
    clear_ports();
    tick();
    tick();
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    set_port(1, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("ar_after_gnt", port_resp, 4'b0001);
    chk("ar_after_addr", mem_address, 32'h600);
    tick();
    clear_ports();
    mem_resp = 1'b0;
    tick();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
